// File: rtl/maj3_vote_sched.sv
// Round-robin time-shared 3-way bitwise majority voter with a saturating disagreement counter.
// Grant is combinational in IDLE; the result is valid two edges after acceptance and held until out_ready.
module maj3_vote_sched #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  input  logic [NREQ*WIDTH-1:0]     req_c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NREQ)-1:0]   out_id,
  output logic                      out_mismatch,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {IDLE, VOTE, HOLD} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     idx_sum;
  logic [IDW-1:0]   next_ptr;
  logic [WIDTH-1:0] maj_word;
  logic             mism;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx_sum >= (IDW+1)'(NREQ)) begin
        idx_sum = idx_sum - (IDW+1)'(NREQ);
      end
      if (req_valid[idx_sum[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_sum[IDW-1:0];
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign req_ready = (rst_n && state == IDLE && grant_found) ? (ONE_HOT0 << grant_idx) : '0;

  assign maj_word = (a_q & b_q) | (b_q & c_q) | (c_q & a_q);
  assign mism     = |((a_q ^ b_q) | (b_q ^ c_q));
  assign next_ptr = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_id       <= '0;
      out_mismatch <= 1'b0;
      err_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            a_q   <= req_a[grant_idx*WIDTH +: WIDTH];
            b_q   <= req_b[grant_idx*WIDTH +: WIDTH];
            c_q   <= req_c[grant_idx*WIDTH +: WIDTH];
            id_q  <= grant_idx;
            state <= VOTE;
          end
        end
        VOTE: begin
          out_data     <= maj_word;
          out_mismatch <= mism;
          out_id       <= id_q;
          out_valid    <= 1'b1;
          if (mism && err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
          end
          state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maj3_vote_sched.sv
// Bench for maj3_vote_sched: directed scenarios plus randomized traffic against a transaction-level model.
module tb_maj3_vote_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid, req_ready, req_ready2;
  logic [NREQ*WIDTH-1:0] req_a, req_b, req_c;
  logic                  out_valid, out_valid2, out_ready, out_mismatch, out_mismatch2;
  logic [WIDTH-1:0]      out_data, out_data2;
  logic [1:0]            out_id, out_id2;
  logic [7:0]            err_cnt;
  logic [1:0]            err_cnt2;

  maj3_vote_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_mismatch(out_mismatch), .err_cnt(err_cnt));

  // Second instance with a 2-bit counter to observe saturation.
  maj3_vote_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_id(out_id2),
    .out_mismatch(out_mismatch2), .err_cnt(err_cnt2));

  int vectors = 0;
  int miscompares = 0;

  int               rr, err;
  bit               rv [NREQ];
  logic [WIDTH-1:0] ra [NREQ];
  logic [WIDTH-1:0] rb [NREQ];
  logic [WIDTH-1:0] rc [NREQ];

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]               = rv[i];
      req_a[i*WIDTH +: WIDTH]    = ra[i];
      req_b[i*WIDTH +: WIDTH]    = rb[i];
      req_c[i*WIDTH +: WIDTH]    = rc[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    apply();
    #1;
  endtask

  // mode 0: independent random words, 1: forced disagreement, 2: all three agree
  task automatic new_data(input int i, input int mode);
    ra[i] = WIDTH'($urandom);
    rb[i] = (mode == 0) ? WIDTH'($urandom) : ra[i];
    rc[i] = (mode == 0) ? WIDTH'($urandom) :
            (mode == 1) ? ra[i] ^ WIDTH'($urandom_range(1, 255)) : ra[i];
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (rv[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] a, b, c);
    logic [WIDTH-1:0] v;
    for (int j = 0; j < WIDTH; j++) begin
      v[j] = (int'(a[j]) + int'(b[j]) + int'(c[j])) >= 2;
    end
    return v;
  endfunction

  function automatic bit disagree(input logic [WIDTH-1:0] a, b, c);
    return !(a == b && b == c);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rc[i] = '0;
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_reqs();
    out_ready = 1'b0;
    settle();
    step();
    rst_n = 1'b1;
    rr = 0;
    err = 0;
  endtask

  task automatic test_reset();
    step();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b1;
    out_ready = 1'b0;
    settle();
    vectors++;
    if ({req_ready, out_valid, out_data, out_id, out_mismatch, err_cnt, err_cnt2} !== '0)
      begin miscompares++; $display("FAIL reset_held: rdy=%b vld=%b data=%h id=%0d mis=%b err=%0d", req_ready, out_valid, out_data, out_id, out_mismatch, err_cnt); end
    step();
    rst_n = 1'b1;
    clear_reqs();
    settle();
    vectors++;
    if ({req_ready, out_valid, err_cnt} !== '0)
      begin miscompares++; $display("FAIL reset_release: rdy=%b vld=%b err=%0d, want all 0", req_ready, out_valid, err_cnt); end
    rr = 0;
    err = 0;
  endtask

  task automatic test_single();
    step();
    rv[0] = 1'b1; ra[0] = 8'hF0; rb[0] = 8'hF0; rc[0] = 8'h0F;
    out_ready = 1'b0;
    settle();
    vectors++;
    if (req_ready !== 4'b0001)
      begin miscompares++; $display("FAIL single_grant: req_ready=%b want 0001", req_ready); end
    step();
    rv[0] = 1'b0;
    settle();
    vectors++;
    if (req_ready !== '0 || out_valid !== 1'b0)
      begin miscompares++; $display("FAIL single_vote_cycle: rdy=%b vld=%b want 0000/0", req_ready, out_valid); end
    step();
    settle();
    vectors++;
    if ({out_valid, out_data, out_id, out_mismatch, err_cnt, err_cnt2} !== {1'b1, 8'hF0, 2'd0, 1'b1, 8'd1, 2'd1})
      begin miscompares++; $display("FAIL single_result: vld=%b data=%h id=%0d mis=%b err=%0d want 1/f0/0/1/1", out_valid, out_data, out_id, out_mismatch, err_cnt); end
    out_ready = 1'b1;
    settle();
    step();
    out_ready = 1'b0;
    settle();
    vectors++;
    if (out_valid !== 1'b0)
      begin miscompares++; $display("FAIL single_drain: out_valid=%b want 0", out_valid); end
    rr = 1;
    err = 1;
  endtask

  task automatic test_agree();
    step();
    rv[2] = 1'b1; ra[2] = 8'h5A; rb[2] = 8'h5A; rc[2] = 8'h5A;
    settle();
    vectors++;
    if (req_ready !== 4'b0100)
      begin miscompares++; $display("FAIL agree_grant: req_ready=%b want 0100", req_ready); end
    step();
    rv[2] = 1'b0;
    settle();
    step();
    settle();
    vectors++;
    if ({out_valid, out_data, out_id, out_mismatch, err_cnt} !== {1'b1, 8'h5A, 2'd2, 1'b0, 8'(err)})
      begin miscompares++; $display("FAIL agree_result: vld=%b data=%h id=%0d mis=%b err=%0d want 1/5a/2/0/%0d", out_valid, out_data, out_id, out_mismatch, err_cnt, err); end
    out_ready = 1'b1;
    settle();
    step();
    out_ready = 1'b0;
    settle();
    rr = 3;
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] ea, eb, ec;
    int g;
    do_reset();
    step();
    for (int i = 0; i < NREQ; i++) begin rv[i] = 1'b1; new_data(i, 0); end
    out_ready = 1'b1;
    settle();
    for (int r = 0; r < 5; r++) begin
      g = r % NREQ;
      vectors++;
      if (req_ready !== onehot(g))
        begin miscompares++; $display("FAIL rr_grant_%0d: req_ready=%b want %b", r, req_ready, onehot(g)); end
      ea = ra[g]; eb = rb[g]; ec = rc[g];
      step();
      new_data(g, 0);
      settle();
      vectors++;
      if (req_ready !== '0 || out_valid !== 1'b0)
        begin miscompares++; $display("FAIL rr_gap_%0d: rdy=%b vld=%b want 0000/0", r, req_ready, out_valid); end
      step();
      settle();
      err += int'(disagree(ea, eb, ec));
      vectors++;
      if ({out_valid, out_id, out_data, out_mismatch, err_cnt, err_cnt2} !==
          {1'b1, 2'(g), vote(ea, eb, ec), disagree(ea, eb, ec), 8'(sat(err, 255)), 2'(sat(err, 3))})
        begin miscompares++; $display("FAIL rr_result_%0d: vld=%b id=%0d data=%h mis=%b err=%0d/%0d want id %0d data %h", r, out_valid, out_id, out_data, out_mismatch, err_cnt, err_cnt2, g, vote(ea, eb, ec)); end
      step();
      settle();
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] expd;
    do_reset();
    step();
    for (int i = 0; i < NREQ; i++) begin rv[i] = 1'b1; new_data(i, 0); end
    out_ready = 1'b0;
    settle();
    vectors++;
    if (req_ready !== 4'b0001)
      begin miscompares++; $display("FAIL bp_grant: req_ready=%b want 0001", req_ready); end
    expd = vote(ra[0], rb[0], rc[0]);
    step();
    new_data(0, 0);
    settle();
    for (int c = 0; c < 5; c++) begin
      step();
      settle();
      vectors++;
      if ({out_valid, out_data, out_id, req_ready} !== {1'b1, expd, 2'd0, 4'b0000})
        begin miscompares++; $display("FAIL bp_hold_%0d: vld=%b data=%h id=%0d rdy=%b want 1/%h/0/0000", c, out_valid, out_data, out_id, req_ready, expd); end
    end
    step();
    out_ready = 1'b1;
    settle();
    step();
    out_ready = 1'b0;
    settle();
    vectors++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0010)
      begin miscompares++; $display("FAIL bp_release: vld=%b rdy=%b want 0/0010", out_valid, req_ready); end
  endtask

  task automatic test_saturation();
    int g;
    int tab [5];
    tab = '{1, 2, 3, 3, 3};
    do_reset();
    for (int v = 0; v < 5; v++) begin
      step();
      clear_reqs();
      g = $urandom_range(0, NREQ - 1);
      rv[g] = 1'b1;
      new_data(g, 1);
      out_ready = 1'b1;
      settle();
      vectors++;
      if (req_ready !== onehot(g))
        begin miscompares++; $display("FAIL sat_grant_%0d: req_ready=%b want %b", v, req_ready, onehot(g)); end
      step();
      rv[g] = 1'b0;
      settle();
      step();
      settle();
      vectors++;
      if ({out_valid, out_mismatch, err_cnt2, err_cnt} !== {1'b1, 1'b1, 2'(tab[v]), 8'(v + 1)})
        begin miscompares++; $display("FAIL sat_count_%0d: vld=%b mis=%b err2=%0d err8=%0d want 1/1/%0d/%0d", v, out_valid, out_mismatch, err_cnt2, err_cnt, tab[v], v + 1); end
    end
    step();
    out_ready = 1'b0;
    settle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    step();
    rv[2] = 1'b1;
    new_data(2, 1);
    settle();
    vectors++;
    if (req_ready !== 4'b0100)
      begin miscompares++; $display("FAIL mid_grant: req_ready=%b want 0100", req_ready); end
    step();
    settle();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, out_valid, out_data, out_id, out_mismatch, err_cnt, err_cnt2} !== '0)
      begin miscompares++; $display("FAIL mid_reset_vote: rdy=%b vld=%b data=%h err=%0d want all 0", req_ready, out_valid, out_data, err_cnt); end
    step();
    rst_n = 1'b1;
    settle();
    vectors++;
    if (req_ready !== 4'b0100)
      begin miscompares++; $display("FAIL mid_regrant_vote: req_ready=%b want 0100", req_ready); end
    step();
    settle();
    step();
    settle();
    vectors++;
    if ({out_valid, out_id, out_mismatch} !== {1'b1, 2'd2, 1'b1})
      begin miscompares++; $display("FAIL mid_hold: vld=%b id=%0d mis=%b want 1/2/1", out_valid, out_id, out_mismatch); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, out_valid, out_data, out_id, out_mismatch, err_cnt, err_cnt2} !== '0)
      begin miscompares++; $display("FAIL mid_reset_hold: rdy=%b vld=%b data=%h id=%0d err=%0d want all 0", req_ready, out_valid, out_data, out_id, err_cnt); end
    step();
    rst_n = 1'b1;
    settle();
    vectors++;
    if (req_ready !== 4'b0100)
      begin miscompares++; $display("FAIL mid_regrant_hold: req_ready=%b want 0100", req_ready); end
  endtask

  // Transaction-level model: grant rule, 2-cycle latency, hold until handshake.
  task automatic test_random();
    bit busy = 1'b0;
    int since = 0;
    int last_g = -1;
    int g, pid;
    logic [WIDTH-1:0] pdata;
    bit pmis, exp_ov;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (i == last_g) begin
          rv[i] = 1'($urandom_range(0, 1));
          if (rv[i]) new_data(i, $urandom_range(0, 2));
        end else if (rv[i]) begin
          if ($urandom_range(0, 7) == 0) rv[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          rv[i] = 1'b1;
          new_data(i, $urandom_range(0, 2));
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      settle();

      g = busy ? -1 : model_grant();
      exp_ov = busy && since >= 1;
      vectors++;
      if (req_ready !== onehot(g) || req_ready2 !== onehot(g) || out_valid !== exp_ov || out_valid2 !== exp_ov)
        begin miscompares++; $display("FAIL rand_ctrl_%0d: rdy=%b vld=%b want %b/%b", cyc, req_ready, out_valid, onehot(g), exp_ov); end
      if (exp_ov) begin
        vectors++;
        if ({out_id, out_data, out_mismatch, out_id2, out_data2, out_mismatch2} !== {2'(pid), pdata, pmis, 2'(pid), pdata, pmis})
          begin miscompares++; $display("FAIL rand_data_%0d: id=%0d data=%h mis=%b want %0d/%h/%b", cyc, out_id, out_data, out_mismatch, pid, pdata, pmis); end
      end
      if (!busy || since >= 1) begin
        vectors++;
        if (err_cnt !== 8'(sat(err, 255)) || err_cnt2 !== 2'(sat(err, 3)))
          begin miscompares++; $display("FAIL rand_err_%0d: err=%0d/%0d want %0d/%0d", cyc, err_cnt, err_cnt2, sat(err, 255), sat(err, 3)); end
      end

      if (exp_ov && out_ready) begin
        busy = 1'b0;
        rr = (pid + 1) % NREQ;
      end else if (busy) begin
        since++;
      end
      last_g = g;
      if (g >= 0) begin
        busy  = 1'b1;
        since = 0;
        pid   = g;
        pdata = vote(ra[g], rb[g], rc[g]);
        pmis  = disagree(ra[g], rb[g], rc[g]);
        err  += int'(pmis);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_reqs();
    out_ready = 1'b0;
    apply();
    rr = 0;
    err = 0;
    test_reset();
    test_single();
    test_agree();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
